// File: rtl/kempston_mouse_pkg.sv
// Shared types and constants for the Kempston mouse front-end.
package kempston_mouse_pkg;

  typedef enum logic [2:0] {DELAY, INHIBIT, TX, ACK, STREAM} mouse_state_t;

  localparam logic [7:0] PORT_LO    = 8'hDF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/kempston_mouse_if.sv
// CPU port-read bus shared by the mouse and the other port sources.
interface kempston_mouse_if;
  logic        en;
  logic        ioreq;
  logic        rd;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_out_active;

  modport master (output en, ioreq, rd, a, input d_out, d_out_active);
  modport slave  (input en, ioreq, rd, a, output d_out, d_out_active);
endinterface

// File: rtl/kempston_mouse_line.sv
// PS/2 line conditioning: synchronisers, clock glitch filter, fall detect,
// 11-bit receive shifter with frame check and inter-bit timeout.
module ps2_mouse_line #(
  parameter int TO_CYC = 56_000
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  input  logic       i_rx_en,
  input  logic       i_tx_busy,
  output logic       o_fall,
  output logic       o_dat,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_rx_err,
  output logic       o_timeout
);
  localparam int TW = $clog2(TO_CYC + 1);

  logic [1:0]    r_csync, r_dsync;
  logic [2:0]    r_fcnt;
  logic          r_filt, r_filt_d;
  logic [3:0]    r_bcnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_to;
  logic [10:0]   w_frame;
  logic          w_last, w_ok, w_armed;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_csync  <= 2'b11;
      r_dsync  <= 2'b11;
      r_fcnt   <= '0;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
    end else begin
      r_csync  <= {r_csync[0], i_ps2_clk};
      r_dsync  <= {r_dsync[0], i_ps2_dat};
      r_filt_d <= r_filt;
      // level flips only after 8 consecutive samples disagree with it
      if (r_csync[1] == r_filt) r_fcnt <= '0;
      else if (r_fcnt == 3'd7) begin
        r_filt <= r_csync[1];
        r_fcnt <= '0;
      end else r_fcnt <= r_fcnt + 3'd1;
    end
  end

  assign o_fall     = r_filt_d & ~r_filt;
  assign o_dat      = r_dsync[1];
  assign w_frame    = {r_dsync[1], r_shift};
  assign w_last     = o_fall & i_rx_en & (r_bcnt == 4'd10);
  assign w_ok       = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
  assign o_rx_byte  = w_frame[8:1];
  assign o_rx_valid = w_last & w_ok;
  assign o_rx_err   = w_last & ~w_ok;
  assign w_armed    = i_tx_busy | (r_bcnt != 4'd0);
  assign o_timeout  = w_armed & (r_to == TW'(TO_CYC - 1));

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_shift <= '0;
      r_to    <= '0;
    end else begin
      if (!i_rx_en || o_timeout || w_last) r_bcnt <= '0;
      else if (o_fall) begin
        r_shift <= {r_dsync[1], r_shift[9:1]};
        r_bcnt  <= r_bcnt + 4'd1;
      end
      if (!w_armed || o_fall || o_timeout) r_to <= '0;
      else r_to <= r_to + 1'b1;
    end
  end

endmodule

// File: rtl/kempston_mouse.sv
// Kempston mouse: PS/2 init (0xF4), stream packet decode, X/Y/button port reads.
module kempston_mouse
  import kempston_mouse_pkg::*;
#(
  parameter int CLK_FREQ   = 28_000_000,
  parameter int INIT_DELAY = CLK_FREQ / 2
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic             ps2_clk_in,
  input  logic             ps2_dat_in,
  output logic             ps2_clk_oe,
  output logic             ps2_dat_oe,
  output logic             present,
  kempston_mouse_if.slave  bus
);
  localparam int   INH    = CLK_FREQ / 10000;
  localparam int   CMAX   = (INIT_DELAY > INH) ? INIT_DELAY : INH;
  localparam int   CW     = $clog2(CMAX + 1);
  localparam logic TX_PAR = odd_par(CMD_ENABLE);

  mouse_state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_tx_cnt;
  logic [1:0]    r_idx;
  logic [7:0]    r_b0, r_b1, r_x, r_y;
  logic [2:0]    r_btn;
  logic          r_clk_oe, r_dat_oe, r_present;
  logic          w_fall, w_dat, w_rx_valid, w_rx_err, w_timeout, w_bat;
  logic [7:0]    w_rx_byte, w_d;
  logic [1:0]    w_sel;
  logic          w_hit, w_unused_a;

  ps2_mouse_line #(.TO_CYC(CLK_FREQ / 500)) u_line (
    .clk28      (clk28),
    .rst        (rst),
    .i_ps2_clk  (ps2_clk_in),
    .i_ps2_dat  (ps2_dat_in),
    .i_rx_en    (r_state == ACK || r_state == STREAM),
    .i_tx_busy  (r_state == TX),
    .o_fall     (w_fall),
    .o_dat      (w_dat),
    .o_rx_byte  (w_rx_byte),
    .o_rx_valid (w_rx_valid),
    .o_rx_err   (w_rx_err),
    .o_timeout  (w_timeout)
  );

  // hot-plug BAT completion: 0xAA then 0x00 as the first two stream bytes
  assign w_bat = w_rx_valid & (r_idx == 2'd1) & (r_b0 == RSP_BAT) & (w_rx_byte == 8'h00);

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) r_state <= DELAY;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      DELAY:   if (r_cnt == CW'(INIT_DELAY - 1)) w_nxt = INHIBIT;
      INHIBIT: if (r_cnt == CW'(INH - 1)) w_nxt = TX;
      TX: begin
        if (w_timeout) w_nxt = DELAY;
        else if (w_fall && r_tx_cnt == 4'd10) w_nxt = w_dat ? DELAY : ACK;
      end
      ACK: begin
        if (w_timeout || w_rx_err) w_nxt = DELAY;
        else if (w_rx_valid) w_nxt = (w_rx_byte == RSP_ACK) ? STREAM : DELAY;
      end
      STREAM:  if (w_bat) w_nxt = DELAY;
      default: w_nxt = DELAY;
    endcase
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_tx_cnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_present <= 1'b0;
    end else begin
      if (w_nxt != r_state) r_cnt <= '0;
      else if (r_state == DELAY || r_state == INHIBIT) r_cnt <= r_cnt + 1'b1;
      r_clk_oe <= (w_nxt == INHIBIT);
      if (r_state == INHIBIT) begin
        // start bit is pulled low during the last inhibit cycle
        r_dat_oe <= (r_cnt >= CW'(INH - 2));
        r_tx_cnt <= '0;
      end else if (r_state == TX && w_fall) begin
        r_tx_cnt <= r_tx_cnt + 4'd1;
        if (r_tx_cnt < 4'd8) r_dat_oe <= ~CMD_ENABLE[r_tx_cnt[2:0]];
        else                 r_dat_oe <= (r_tx_cnt == 4'd8) ? ~TX_PAR : 1'b0;
      end
      if (w_nxt != INHIBIT && w_nxt != TX) r_dat_oe <= 1'b0;
      if (r_state == ACK && w_nxt == STREAM) r_present <= 1'b1;
      else if (w_nxt == DELAY)               r_present <= 1'b0;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_b0  <= '0;
      r_b1  <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_btn <= '0;
    end else if (r_state != STREAM || w_rx_err || w_timeout) begin
      r_idx <= '0;
    end else if (w_rx_valid) begin
      case (r_idx)
        2'd0: if (w_rx_byte[3]) begin
          r_b0  <= w_rx_byte;
          r_idx <= 2'd1;
        end
        2'd1: begin
          r_b1  <= w_rx_byte;
          r_idx <= 2'd2;
        end
        default: begin
          r_btn <= r_b0[2:0];
          if (!r_b0[6]) r_x <= r_x + r_b1;
          if (!r_b0[7]) r_y <= r_y + w_rx_byte;
          r_idx <= 2'd0;
        end
      endcase
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign present    = r_present;

  // a[9] is don't-care so FBDF/FFDF/FADF alias with a[9]=0
  assign w_sel      = {bus.a[10], bus.a[8]};
  assign w_hit      = bus.en & bus.ioreq & bus.rd & (bus.a[7:0] == PORT_LO) & (w_sel != 2'b10);
  assign w_unused_a = ^{bus.a[15:11], bus.a[9]};

  always_comb begin
    w_d = {5'b11111, ~r_btn[2], ~r_btn[0], ~r_btn[1]};
    case (w_sel)
      2'b01:   w_d = r_x;
      2'b11:   w_d = r_y;
      default: w_d = {5'b11111, ~r_btn[2], ~r_btn[0], ~r_btn[1]};
    endcase
  end

  assign bus.d_out        = w_hit ? w_d : 8'h00;
  assign bus.d_out_active = w_hit;

endmodule

// File: tb/tb_kempston_mouse.sv
// Bench: PS/2 mouse device model plus behavioural X/Y/button reference.
module tb_kempston_mouse;
  localparam int CLK_FREQ   = 500_000;
  localparam int INIT_DELAY = 200;
  localparam int INH        = CLK_FREQ / 10000;
  localparam int TO         = CLK_FREQ / 500;
  localparam int H          = 20;

  logic clk28 = 1'b0, rst = 1'b1, dev_clk = 1'b1, dev_dat = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe, present;
  logic ps2_clk_in, ps2_dat_in;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  kempston_mouse_if bus();

  kempston_mouse #(.CLK_FREQ(CLK_FREQ), .INIT_DELAY(INIT_DELAY)) dut (
    .clk28      (clk28),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .present    (present),
    .bus        (bus)
  );

  always #5 clk28 = ~clk28;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mx = 8'h00, my = 8'h00;
  logic       m_l = 1'b0, m_r = 1'b0, m_m = 1'b0;

  int cyc = 0, t_pdrop = 0, t_inh = 0;
  logic pres_q = 1'b0, coe_q = 1'b0;
  always @(negedge clk28) begin
    cyc    <= cyc + 1;
    if (pres_q && !present)    t_pdrop <= cyc;
    if (!coe_q && ps2_clk_oe)  t_inh   <= cyc;
    pres_q <= present;
    coe_q  <= ps2_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk28);
  endtask

  // device-to-host frame; nbits < 11 leaves a partial frame on the wire
  task automatic dev_send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat = f[i];
      wait_cyc(H / 2);
      dev_clk = 1'b0;
      wait_cyc(H);
      dev_clk = 1'b1;
      wait_cyc(H / 2);
    end
    dev_dat = 1'b1;
    wait_cyc(2 * H);
  endtask

  // a real mouse reports movement as two's complement, so it wraps mod 256
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    dev_send(b0, 1'b0, 11);
    dev_send(b1, 1'b0, 11);
    dev_send(b2, 1'b0, 11);
    m_l = b0[0];
    m_r = b0[1];
    m_m = b0[2];
    if (b0[6] == 1'b0) mx = 8'((int'(mx) + int'(b1)) % 256);
    if (b0[7] == 1'b0) my = 8'((int'(my) + int'(b2)) % 256);
  endtask

  task automatic rd_raw(input logic en, input logic io, input logic r, input logic [15:0] addr,
                        output logic [7:0] d, output logic act);
    bus.en = en; bus.ioreq = io; bus.rd = r; bus.a = addr;
    #1;
    d   = bus.d_out;
    act = bus.d_out_active;
    bus.ioreq = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic chk_pos(input string tag);
    logic [7:0] d;
    logic act;
    rd_raw(1, 1, 1, 16'hFBDF, d, act);
    chk({tag, "_x"}, {23'd0, act, d}, {23'd0, 1'b1, mx});
    rd_raw(1, 1, 1, 16'hFFDF, d, act);
    chk({tag, "_y"}, {23'd0, act, d}, {23'd0, 1'b1, my});
    rd_raw(1, 1, 1, 16'hFADF, d, act);
    chk({tag, "_btn"}, {23'd0, act, d}, {23'd0, 1'b1, 5'b11111, ~m_m, ~m_l, ~m_r});
  endtask

  // host-to-device: bits[0]=start, [8:1]=data, [9]=parity, [10]=stop
  task automatic host_rx(input bit ack_bit, output logic [10:0] bits, output int hold);
    int wc;
    wc = 0; hold = 0; bits = '0;
    while (!ps2_clk_oe && wc < 5000) begin wait_cyc(1); wc++; end
    if (!ps2_clk_oe) begin
      chk("inhibit_seen", 0, 1);
      return;
    end
    while (ps2_clk_oe && hold < 5000) begin wait_cyc(1); hold++; end
    bits[0] = ps2_dat_in;
    wait_cyc(H);
    for (int k = 1; k <= 10; k++) begin
      wait_cyc(H / 2);
      dev_clk = 1'b0;
      wait_cyc(H);
      dev_clk = 1'b1;
      bits[k] = ps2_dat_in;
      wait_cyc(H / 2);
    end
    dev_dat = ack_bit;
    wait_cyc(H / 2);
    dev_clk = 1'b0;
    wait_cyc(H);
    dev_clk = 1'b1;
    wait_cyc(H / 2);
    dev_dat = 1'b1;
  endtask

  task automatic chk_cmd(input string tag, input logic [10:0] bits, input int hold);
    chk({tag, "_start"}, {31'd0, bits[0]}, 0);
    chk({tag, "_byte"}, {24'd0, bits[8:1]}, 32'hF4);
    chk({tag, "_par"}, {31'd0, bits[9]}, 0);
    chk({tag, "_stop"}, {31'd0, bits[10]}, 1);
    chk({tag, "_hold"}, {31'd0, hold >= INH}, 1);
  endtask

  task automatic do_init(input string tag);
    logic [10:0] bits;
    int hold;
    host_rx(1'b0, bits, hold);
    chk_cmd(tag, bits, hold);
    wait_cyc(H);
    dev_send(8'hFA, 1'b0, 11);
    wait_cyc(4);
    chk({tag, "_present"}, {31'd0, present}, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    logic [7:0]  d, b0;
    logic        act;
    int          hold, dly, wc;

    bus.en = 1'b0; bus.ioreq = 1'b0; bus.rd = 1'b0; bus.a = '0;
    wait_cyc(3);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    chk("rst_present", {31'd0, present}, 0);
    chk_pos("rst");
    rst = 1'b0;

    do_init("init");

    send_pkt(8'h08, 8'h05, 8'hFE);
    chk_pos("pkt1");
    send_pkt(8'h09, 8'h03, 8'h01);
    chk_pos("pkt2");

    send_pkt(8'h08, 8'hF6, 8'h00);
    chk("x_fe", {24'd0, mx}, 32'hFE);
    chk_pos("to_fe");
    send_pkt(8'h48, 8'h10, 8'h02);
    chk_pos("xovf");
    send_pkt(8'h08, 8'h03, 8'h00);
    chk_pos("xwrap");

    dev_send(8'h08, 1'b0, 11);
    dev_send(8'h20, 1'b1, 11);
    dev_send(8'h00, 1'b0, 11);
    chk_pos("badpar");
    send_pkt(8'h0C, 8'h04, 8'h04);
    chk_pos("after_badpar");

    dev_send(8'h00, 1'b0, 11);
    send_pkt(8'h0A, 8'h11, 8'h22);
    chk_pos("skip0");

    dev_send(8'h08, 1'b0, 11);
    dev_send(8'h55, 1'b0, 5);
    wait_cyc(TO * 3 / 2);
    chk_pos("partial");
    send_pkt(8'h08, 8'h02, 8'h02);
    chk_pos("after_tmo");

    for (int i = 0; i < 8; i++) begin
      b0 = 8'($urandom_range(0, 255)) | 8'h08;
      if (b0 == 8'hAA) b0 = 8'hAB;
      send_pkt(b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      chk_pos($sformatf("rnd%0d", i));
    end

    rd_raw(0, 1, 1, 16'hFBDF, d, act);
    chk("dec_en0", {31'd0, act}, 0);
    rd_raw(1, 1, 1, 16'hFEDF, d, act);
    chk("dec_fedf", {31'd0, act}, 0);
    rd_raw(1, 1, 0, 16'hFBDF, d, act);
    chk("dec_rd0", {31'd0, act}, 0);
    rd_raw(1, 0, 1, 16'hFBDF, d, act);
    chk("dec_io0", {31'd0, act}, 0);
    rd_raw(1, 1, 1, 16'hFBDE, d, act);
    chk("dec_lo", {31'd0, act}, 0);
    rd_raw(1, 1, 1, 16'hF9DF, d, act);
    chk("dec_a9", {23'd0, act, d}, {23'd0, 1'b1, mx});

    dev_send(8'hAA, 1'b0, 11);
    dev_send(8'h00, 1'b0, 11);
    chk("bat_present", {31'd0, present}, 0);
    host_rx(1'b1, bits, hold);
    chk_cmd("nak", bits, hold);
    dly = t_inh - t_pdrop;
    chk("reinit_delay", {31'd0, dly >= INIT_DELAY && dly <= INIT_DELAY + 2}, 1);
    wait_cyc(4);
    chk("nak_present", {31'd0, present}, 0);
    do_init("retry");
    chk_pos("kept");

    dev_send(8'hAA, 1'b0, 11);
    dev_send(8'h00, 1'b0, 11);
    wc = 0;
    while (!ps2_clk_oe && wc < 5000) begin wait_cyc(1); wc++; end
    while (ps2_clk_oe && wc < 10000) begin wait_cyc(1); wc++; end
    wait_cyc(H);
    chk("tx_dat_low", {31'd0, ps2_dat_oe}, 1);
    rst = 1'b1;
    #1;
    chk("rst_tx_clk", {31'd0, ps2_clk_oe}, 0);
    chk("rst_tx_dat", {31'd0, ps2_dat_oe}, 0);
    mx = 8'h00; my = 8'h00; m_l = 1'b0; m_r = 1'b0; m_m = 1'b0;
    chk_pos("rst_tx");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
